// File: rtl/seg_scan_if.sv
// Load-side inputs and segment/digit drive outputs of the 3-digit display scanner.
interface seg_scan_if;
   logic       load;
   logic [7:0] value;
   logic       base_hex;
   logic       blank_lz;
   logic       err;
   logic [6:0] seg;
   logic [2:0] dig_en;
   logic       frame_done;

   modport master (output load, value, base_hex, blank_lz, err,
                   input  seg, dig_en, frame_done);
   modport slave  (input  load, value, base_hex, blank_lz, err,
                   output seg, dig_en, frame_done);
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 3-digit common-anode 7-segment scanner with octal/hex decode,
// leading-zero blanking, error blink and frame-synchronous double buffering.
module seg_scan_ctrl #(
   parameter int unsigned DIV      = 50000,
   parameter int unsigned GAP      = 16,
   parameter int unsigned BLINK_FR = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   seg_scan_if.slave bus
);

   localparam int unsigned CMAX = (DIV > GAP) ? DIV : GAP;
   localparam int unsigned CW   = $clog2(CMAX + 1);
   localparam int unsigned FW   = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
   localparam logic [6:0]  SEG_BLANK = 7'b1111111;
   localparam logic [6:0]  SEG_DASH  = 7'b0111111;

   typedef struct packed {
      logic [7:0] value;
      logic       base_hex;
      logic       blank_lz;
      logic       err;
   } disp_t;

   typedef enum logic {S_SHOW, S_GAP} state_t;

   function automatic logic [6:0] glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
         4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
         4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
         4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
         4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
         4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
         4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
         4'hE: g = 7'b0000110;  default: g = 7'b0001110;
      endcase
      return g;
   endfunction

   state_t          state_q, state_d;
   logic [1:0]      idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   disp_t           shadow_q, shadow_d;
   disp_t           disp_q, disp_d;
   logic            phase_q, phase_d;
   logic [FW-1:0]   fcnt_q, fcnt_d;
   logic [6:0]      seg_q, seg_d;
   logic [2:0]      dig_en_q, dig_en_d;
   logic            fd_q, fd_d;

   logic            advance, boundary;
   logic [3:0]      d0, d1, d2;
   logic            bl1, bl2;
   logic [6:0]      sel;

   // Next-state logic; outputs are decoded from the next state so they register in step with it.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q + CW'(1);
      shadow_d = shadow_q;
      disp_d   = disp_q;
      phase_d  = phase_q;
      fcnt_d   = fcnt_q;
      advance  = 1'b0;
      boundary = 1'b0;
      d0 = 4'h0; d1 = 4'h0; d2 = 4'h0;
      bl1 = 1'b0; bl2 = 1'b0;
      sel      = SEG_BLANK;
      seg_d    = SEG_BLANK;
      dig_en_d = 3'b111;
      fd_d     = 1'b0;

      if (bus.load) shadow_d = {bus.value, bus.base_hex, bus.blank_lz, bus.err};

      case (state_q)
         S_SHOW: if (cnt_q == CW'(DIV)) begin
            if (GAP == 0) advance = 1'b1;
            else begin
               state_d = S_GAP;
               cnt_d   = CW'(1);
            end
         end
         S_GAP: if (cnt_q == CW'(GAP)) advance = 1'b1;
         default: state_d = S_SHOW;
      endcase

      if (advance) begin
         state_d  = S_SHOW;
         cnt_d    = CW'(1);
         boundary = (idx_q == 2'd2);
         idx_d    = boundary ? 2'd0 : idx_q + 2'd1;
      end

      // Frame boundary: commit shadow and step the blink phase (restart on entering/leaving error).
      if (boundary) begin
         disp_d = shadow_q;
         fd_d   = 1'b1;
         if (!shadow_q.err || !disp_q.err) begin
            phase_d = 1'b1;
            fcnt_d  = '0;
         end else if (fcnt_q == FW'(BLINK_FR - 1)) begin
            phase_d = ~phase_q;
            fcnt_d  = '0;
         end else begin
            fcnt_d  = fcnt_q + FW'(1);
         end
      end

      if (disp_d.base_hex) begin
         d0  = disp_d.value[3:0];
         d1  = disp_d.value[7:4];
         bl2 = 1'b1;
      end else begin
         d0  = {1'b0, disp_d.value[2:0]};
         d1  = {1'b0, disp_d.value[5:3]};
         d2  = {2'b00, disp_d.value[7:6]};
         bl2 = disp_d.blank_lz && (d2 == 4'h0);
      end
      bl1 = disp_d.blank_lz && (d1 == 4'h0) && bl2;

      case (idx_d)
         2'd0:    sel = glyph(d0);
         2'd1:    sel = bl1 ? SEG_BLANK : glyph(d1);
         default: sel = bl2 ? SEG_BLANK : glyph(d2);
      endcase
      if (disp_d.err) sel = phase_d ? SEG_DASH : SEG_BLANK;

      if (state_d == S_SHOW) begin
         seg_d = sel;
         case (idx_d)
            2'd0:    dig_en_d = 3'b110;
            2'd1:    dig_en_d = 3'b101;
            default: dig_en_d = 3'b011;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_SHOW;
         idx_q    <= 2'd0;
         cnt_q    <= '0;
         shadow_q <= '0;
         disp_q   <= '0;
         phase_q  <= 1'b1;
         fcnt_q   <= '0;
         seg_q    <= SEG_BLANK;
         dig_en_q <= 3'b111;
         fd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         disp_q   <= disp_d;
         phase_q  <= phase_d;
         fcnt_q   <= fcnt_d;
         seg_q    <= seg_d;
         dig_en_q <= dig_en_d;
         fd_q     <= fd_d;
      end
   end

   assign bus.seg        = seg_q;
   assign bus.dig_en     = dig_en_q;
   assign bus.frame_done = fd_q;

endmodule
